// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage with program counter. Each 32-bit instruction is
//   gathered as four byte reads over a byte-wide memory port with one-cycle
//   read latency. The assembled word is presented to the IF/ID register and
//   handed off when the stall controller lets the PC and IF stages advance.
//   A branch redirect from EX discards any fetch in progress.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   stall[5:0]       stall vector; bit0 holds the PC, bit1 holds IF
//   branch_flag_i    single-cycle redirect request from EX
//   branch_target_i  redirect target PC
//   mem_grant_i      arbiter accepts this cycle's byte read
//   mem_din[7:0]     data for the read granted in the previous cycle
//   mem_rd           byte read request
//   mem_a            byte address (pc + issue_idx)
//   if_pc_o          PC of the presented instruction
//   if_inst_o        assembled little-endian instruction
//   if_valid_o       if_inst_o / if_pc_o valid this cycle
//   stallreq_if      fetch still in progress
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  branch_flag_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic                  mem_grant_i,
  input  logic [7:0]            mem_din,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [31:0]           if_inst_o,
  output logic                  if_valid_o,
  output logic                  stallreq_if
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [2:0]            issue_idx_q, issue_idx_d;
  logic [2:0]            cap_idx_q, cap_idx_d;
  logic                  pending_q, pending_d;
  logic [1:0]            pend_slot_q, pend_slot_d;
  logic [3:0][7:0]       byte_buf_q, byte_buf_d;
  // Marks the dead cycle right after reset: nothing issues or captures.
  logic                  post_rst_q, post_rst_d;

  logic active;
  logic done;
  logic issue_ok;
  logic unused_stall;

  assign unused_stall = ^stall[5:2];

  assign active   = !post_rst_q;
  assign done     = (cap_idx_q == 3'd4);
  assign issue_ok = active && (issue_idx_q < 3'd4) && !branch_flag_i;

  // Request/address generation and the presented instruction. The reset
  // gating keeps outputs quiet in the reset cycle itself, before the
  // synchronous reset has cleared the registers.
  always_comb begin
    mem_rd      = !rst && issue_ok;
    mem_a       = pc_q + ADDR_WIDTH'(issue_idx_q);
    if_valid_o  = !rst && active && done && !branch_flag_i;
    stallreq_if = !rst && active && !done;
    if_inst_o   = rst ? 32'h0 : byte_buf_q;
    if_pc_o     = rst ? RESET_PC : pc_q;
  end

  // Next-state logic. A branch wins over capture, hand-off and stall; the
  // byte in flight is dropped by clearing pending without capturing it.
  always_comb begin
    pc_d        = pc_q;
    issue_idx_d = issue_idx_q;
    cap_idx_d   = cap_idx_q;
    pending_d   = 1'b0;
    pend_slot_d = pend_slot_q;
    byte_buf_d  = byte_buf_q;
    post_rst_d  = 1'b0;

    if (active) begin
      if (branch_flag_i) begin
        pc_d        = branch_target_i;
        issue_idx_d = 3'd0;
        cap_idx_d   = 3'd0;
      end else begin
        if (issue_ok && mem_grant_i) begin
          issue_idx_d = issue_idx_q + 3'd1;
          pending_d   = 1'b1;
          pend_slot_d = issue_idx_q[1:0];
        end
        if (pending_q) begin
          byte_buf_d[pend_slot_q] = mem_din;
          cap_idx_d               = cap_idx_q + 3'd1;
        end
        // Stall bits only matter once the word is complete.
        if (done && (stall[1:0] == 2'b00)) begin
          pc_d        = pc_q + ADDR_WIDTH'(4);
          issue_idx_d = 3'd0;
          cap_idx_d   = 3'd0;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      issue_idx_q <= 3'd0;
      cap_idx_q   <= 3'd0;
      pending_q   <= 1'b0;
      pend_slot_q <= 2'd0;
      byte_buf_q  <= '0;
      post_rst_q  <= 1'b1;
    end else begin
      pc_q        <= pc_d;
      issue_idx_q <= issue_idx_d;
      cap_idx_q   <= cap_idx_d;
      pending_q   <= pending_d;
      pend_slot_q <= pend_slot_d;
      byte_buf_q  <= byte_buf_d;
      post_rst_q  <= post_rst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
module tb_if_fetch_unit;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        mem_grant_i;
   logic [7:0]  mem_din;
   logic        mem_rd;
   logic [31:0] mem_a;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_valid_o;
   logic        stallreq_if;

   int          vecCount;
   int          errCount;
   logic        lastReq;
   logic [31:0] lastAddr;

   if_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .branch_flag_i(branch_flag_i),
      .branch_target_i(branch_target_i),
      .mem_grant_i(mem_grant_i),
      .mem_din(mem_din),
      .mem_rd(mem_rd),
      .mem_a(mem_a),
      .if_pc_o(if_pc_o),
      .if_inst_o(if_inst_o),
      .if_valid_o(if_valid_o),
      .stallreq_if(stallreq_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: the first word is a fixed instruction, the rest is a
   // simple address-derived pattern so expected words can be worked by hand.
   function automatic logic [7:0] memByte(input logic [31:0] a);
      case (a)
         32'h0:   memByte = 8'h13;
         32'h1:   memByte = 8'h05;
         32'h2:   memByte = 8'h10;
         32'h3:   memByte = 8'h00;
         default: memByte = (a[7:0] + 8'h5A) ^ a[31:24];
      endcase
   endfunction

   // One-cycle read latency: a request granted in a cycle returns its byte in
   // the next cycle; otherwise a junk value sits on the bus.
   always @(posedge clk) begin
      mem_din <= lastReq ? memByte(lastAddr) : 8'hEE;
   end

   // Drives one cycle of inputs after the falling edge, then records the
   // memory request the DUT makes in that cycle.
   task automatic applyStimulus(input logic r, input logic [5:0] st,
                                input logic br, input logic [31:0] tgt,
                                input logic gnt);
      @(negedge clk);
      rst             = r;
      stall           = st;
      branch_flag_i   = br;
      branch_target_i = tgt;
      mem_grant_i     = gnt;
      #1;
      lastReq  = mem_rd && mem_grant_i;
      lastAddr = mem_a;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      vecCount = 0;
      errCount = 0;
      lastReq  = 1'b0;
      lastAddr = 32'h0;
      mem_din  = 8'h00;
      rst = 1'b1; stall = 6'h0; branch_flag_i = 1'b0;
      branch_target_i = 32'h0; mem_grant_i = 1'b1;

      // Reset and the dead cycle after release.
      applyStimulus(1, 6'h0, 0, 32'h0, 1);
      checkOutput("rst_rd", 32'(mem_rd), 0);
      checkOutput("rst_valid", 32'(if_valid_o), 0);
      checkOutput("rst_stallreq", 32'(stallreq_if), 0);
      checkOutput("rst_pc", if_pc_o, 32'h0);
      checkOutput("rst_inst", if_inst_o, 32'h0);
      applyStimulus(1, 6'h0, 0, 32'h0, 1);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("post_rd", 32'(mem_rd), 0);
      checkOutput("post_valid", 32'(if_valid_o), 0);
      checkOutput("post_stallreq", 32'(stallreq_if), 0);

      // First fetch with continuous grant.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 6'h0, 0, 32'h0, 1);
         checkOutput("f1_rd", 32'(mem_rd), 1);
         checkOutput("f1_addr", mem_a, 32'(i));
      end
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("f1_t4_rd", 32'(mem_rd), 0);
      checkOutput("f1_t4_valid", 32'(if_valid_o), 0);
      checkOutput("f1_t4_stallreq", 32'(stallreq_if), 1);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("f1_valid", 32'(if_valid_o), 1);
      checkOutput("f1_inst", if_inst_o, 32'h00100513);
      checkOutput("f1_pc", if_pc_o, 32'h0);
      checkOutput("f1_stallreq", 32'(stallreq_if), 0);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("f2_addr", mem_a, 32'h4);
      checkOutput("f2_rd", 32'(mem_rd), 1);
      checkOutput("f2_pc", if_pc_o, 32'h4);

      // Refetch from reset with the grant withheld for two cycles.
      applyStimulus(1, 6'h0, 0, 32'h0, 1);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("g_t0_addr", mem_a, 32'h0);
      applyStimulus(0, 6'h0, 0, 32'h0, 0);
      checkOutput("g_t1_addr", mem_a, 32'h1);
      applyStimulus(0, 6'h0, 0, 32'h0, 0);
      checkOutput("g_t2_addr", mem_a, 32'h1);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("g_t3_addr", mem_a, 32'h1);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("g_t4_addr", mem_a, 32'h2);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("g_t5_addr", mem_a, 32'h3);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("g_t6_valid", 32'(if_valid_o), 0);

      // Stall for four cycles starting at the first valid cycle.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 6'b000111, 0, 32'h0, 1);
         checkOutput("stall_valid", 32'(if_valid_o), 1);
         checkOutput("stall_inst", if_inst_o, 32'h00100513);
         checkOutput("stall_pc", if_pc_o, 32'h0);
      end
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("release_valid", 32'(if_valid_o), 1);
      checkOutput("release_pc", if_pc_o, 32'h0);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("after_pc", if_pc_o, 32'h4);
      checkOutput("after_addr", mem_a, 32'h4);
      checkOutput("after_valid", 32'(if_valid_o), 0);

      // Branch to 0x100 while two bytes have been captured.
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      applyStimulus(0, 6'h0, 1, 32'h100, 1);
      checkOutput("br_rd", 32'(mem_rd), 0);
      checkOutput("br_valid", 32'(if_valid_o), 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 6'h0, 0, 32'h0, 1);
         checkOutput("br_fetch_rd", 32'(mem_rd), 1);
         checkOutput("br_fetch_addr", mem_a, 32'h100 + 32'(i));
      end
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("br_t4_valid", 32'(if_valid_o), 0);
      applyStimulus(0, 6'b000011, 0, 32'h0, 1);
      checkOutput("br_valid_word", 32'(if_valid_o), 1);
      checkOutput("br_inst", if_inst_o, 32'h5D5C5B5A);
      checkOutput("br_pc", if_pc_o, 32'h100);

      // Branch in a done cycle: no hand-off, target fetched instead.
      applyStimulus(0, 6'h0, 1, 32'hFFFFFFFC, 1);
      checkOutput("brdone_valid", 32'(if_valid_o), 0);
      checkOutput("brdone_rd", 32'(mem_rd), 0);

      // Fetch at the top of the address space, then wrap on hand-off.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 6'h0, 0, 32'h0, 1);
         checkOutput("wrap_addr", mem_a, 32'hFFFFFFFC + 32'(i));
         checkOutput("wrap_pc", if_pc_o, 32'hFFFFFFFC);
      end
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("wrap_valid", 32'(if_valid_o), 1);
      checkOutput("wrap_inst", if_inst_o, 32'hA6A7A8A9);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("wrap_next_pc", if_pc_o, 32'h0);
      checkOutput("wrap_next_addr", mem_a, 32'h0);

      // Reset in the middle of a fetch.
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("mid_addr", mem_a, 32'h1);
      applyStimulus(1, 6'h0, 0, 32'h0, 1);
      checkOutput("midrst_stallreq", 32'(stallreq_if), 0);
      checkOutput("midrst_rd", 32'(mem_rd), 0);
      checkOutput("midrst_valid", 32'(if_valid_o), 0);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("midrst_post_rd", 32'(mem_rd), 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 6'h0, 0, 32'h0, 1);
         checkOutput("refetch_addr", mem_a, 32'(i));
      end
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      applyStimulus(0, 6'h0, 0, 32'h0, 1);
      checkOutput("refetch_valid", 32'(if_valid_o), 1);
      checkOutput("refetch_inst", if_inst_o, 32'h00100513);
      checkOutput("refetch_pc", if_pc_o, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
